// File: rtl/spidac_pkg.sv
// rtl/spidac_pkg.sv - frame layout, FSM states and readback offsets shared by spidac and spidac_rx
package spidac_pkg;

  localparam int FRAME_BITS_DEFAULT = 16;

  localparam int CH_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int GAIN_BIT = 13;
  localparam int SHDN_BIT = 12;
  localparam int CODE_MSB = 11;
  localparam int CODE_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] RB_DAC_A_LO = 8'd0;
  localparam logic [7:0] RB_DAC_A_HI = 8'd1;
  localparam logic [7:0] RB_DAC_B_LO = 8'd2;
  localparam logic [7:0] RB_DAC_B_HI = 8'd3;
  localparam logic [7:0] RB_FRAMES   = 8'd4;
  localparam logic [7:0] RB_STATUS   = 8'd5;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - pin synchroniser with registered rise/fall pulses
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Shift form keeps SYNC_STAGES == 1 legal.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(pin);
      edge_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~edge_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & edge_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spidac_rx.sv
// rtl/spidac_rx.sv - oversampling SPI responder emulating a dual 12-bit DAC with readback
module spidac_rx import spidac_pkg::*; #(
  parameter int         FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BASE_ADDR   = 8'h40
) (
  input  logic        clock50Mhz,
  input  logic        reset,
  input  logic        SCK,
  input  logic        nCS,
  input  logic        nLDAC,
  input  logic        SDI,
  input  logic [7:0]  addr,
  output logic [7:0]  data_out,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [2:0]  ctl_a,
  output logic [2:0]  ctl_b,
  output logic        frame_valid,
  output logic        frame_err
);

  logic sck_lvl, sck_rise, sck_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic ldac_lvl, ldac_rise, ldac_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(clock50Mhz), .reset(reset), .pin(SCK),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs (
    .clk(clock50Mhz), .reset(reset), .pin(nCS),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ldac (
    .clk(clock50Mhz), .reset(reset), .pin(nLDAC),
    .level(ldac_lvl), .rise(ldac_rise), .fall(ldac_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
    .clk(clock50Mhz), .reset(reset), .pin(SDI),
    .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, sck_lvl, sck_fall, ncs_lvl, ldac_lvl, ldac_rise, sdi_rise, sdi_fall};

  state_t                state, state_nx;
  logic [FRAME_BITS-1:0] shreg;
  logic [4:0]            bit_cnt;
  logic [11:0]           in_code_a, in_code_b;
  logic [2:0]            in_ctl_a, in_ctl_b;
  logic [7:0]            frame_cnt;
  logic                  err_sticky;
  logic                  busy;

  always_ff @(posedge clock50Mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    frame_valid = 1'b0;
    frame_err   = 1'b0;
    case (state)
      IDLE:  if (ncs_fall) state_nx = SHIFT;
      SHIFT: if (ncs_rise) state_nx = CHECK;
      CHECK: begin
        if (bit_cnt == 5'(FRAME_BITS)) frame_valid = 1'b1;
        else                           frame_err   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Input and output registers update on the same edge, so an nLDAC fall
  // coinciding with a commit transfers the pre-commit codes.
  always_ff @(posedge clock50Mhz) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      in_code_a  <= '0;
      in_code_b  <= '0;
      in_ctl_a   <= '0;
      in_ctl_b   <= '0;
      dac_a      <= '0;
      dac_b      <= '0;
      ctl_a      <= '0;
      ctl_b      <= '0;
      frame_cnt  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (state == IDLE && ncs_fall) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT && sck_rise) begin
        shreg <= {shreg[FRAME_BITS-2:0], sdi_lvl};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end

      if (frame_valid) begin
        if (shreg[CH_BIT]) begin
          in_code_b <= shreg[CODE_MSB:CODE_LSB];
          in_ctl_b  <= {shreg[SHDN_BIT], shreg[GAIN_BIT], shreg[BUF_BIT]};
        end else begin
          in_code_a <= shreg[CODE_MSB:CODE_LSB];
          in_ctl_a  <= {shreg[SHDN_BIT], shreg[GAIN_BIT], shreg[BUF_BIT]};
        end
        frame_cnt <= frame_cnt + 8'd1;
      end

      if (frame_err) err_sticky <= 1'b1;

      if (ldac_fall) begin
        dac_a <= in_code_a;
        dac_b <= in_code_b;
        ctl_a <= in_ctl_a;
        ctl_b <= in_ctl_b;
      end
    end
  end

  assign busy = (state != IDLE);

  logic [7:0] rb_off;
  assign rb_off = addr - BASE_ADDR;

  // Addresses below BASE_ADDR wrap to large offsets and read as zero.
  always_comb begin
    data_out = 8'h00;
    case (rb_off)
      RB_DAC_A_LO: data_out = dac_a[7:0];
      RB_DAC_A_HI: data_out = {1'b0, ctl_a, dac_a[11:8]};
      RB_DAC_B_LO: data_out = dac_b[7:0];
      RB_DAC_B_HI: data_out = {1'b0, ctl_b, dac_b[11:8]};
      RB_FRAMES:   data_out = frame_cnt;
      RB_STATUS:   data_out = {6'b0, err_sticky, busy};
      default:     data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_spidac_rx.sv
// tb/tb_spidac_rx.sv - directed self-checking bench for spidac_rx
module tb_spidac_rx;

  localparam logic [7:0] BASE = 8'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCK, nCS, nLDAC, SDI;
  logic [7:0]  addr;
  logic [7:0]  data_out;
  logic [11:0] dac_a, dac_b;
  logic [2:0]  ctl_a, ctl_b;
  logic        frame_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int vld_base, err_base;

  spidac_rx #(.FRAME_BITS(16), .SYNC_STAGES(2), .BASE_ADDR(BASE)) dut (
    .clock50Mhz(clk), .reset(reset), .SCK(SCK), .nCS(nCS), .nLDAC(nLDAC), .SDI(SDI),
    .addr(addr), .data_out(data_out), .dac_a(dac_a), .dac_b(dac_b),
    .ctl_a(ctl_a), .ctl_b(ctl_b), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_valid === 1'b1) vld_cnt <= vld_cnt + 1;
    if (frame_err === 1'b1)   err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, {24'h0, data_out}, {24'h0, exp});
  endtask

  // nCS low, then n bits MSB first; SCK phases of 4 clocks meet the SYNC_STAGES+2 minimum.
  task automatic send_bits(input logic [31:0] word, input int n);
    nCS = 1'b0;
    clk_n(6);
    for (int i = n - 1; i >= 0; i--) begin
      SDI = word[i];
      clk_n(4);
      SCK = 1'b1;
      clk_n(4);
      SCK = 1'b0;
    end
    clk_n(4);
  endtask

  task automatic end_frame();
    nCS = 1'b1;
    clk_n(10);
  endtask

  task automatic send_frame(input logic [15:0] word);
    send_bits({16'h0, word}, 16);
    end_frame();
  endtask

  task automatic ldac_pulse();
    nLDAC = 1'b0;
    clk_n(6);
    nLDAC = 1'b1;
    clk_n(6);
  endtask

  initial begin
    reset = 1'b1;
    SCK = 1'b0; nCS = 1'b1; nLDAC = 1'b1; SDI = 1'b0; addr = 8'h00;
    clk_n(4);
    reset = 1'b0;
    clk_n(8);

    check("rst_dac_a", 32'(dac_a), 32'h0);
    check("rst_dac_b", 32'(dac_b), 32'h0);
    check("rst_ctl_a", 32'(ctl_a), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check_rd("rst_cnt", BASE + 8'd4, 8'h00);
    check_rd("rst_status", BASE + 8'd5, 8'h00);

    // Frame 1ABC: ch A, shdn_n=1, code ABC; latency nCS rise -> valid = 4 clocks
    vld_base = vld_cnt;
    send_bits(32'h1ABC, 16);
    nCS = 1'b1;
    clk_n(3);
    check("lat_valid_early", 32'(frame_valid), 32'h0);
    clk_n(1);
    check("lat_valid", 32'(frame_valid), 32'h1);
    check("lat_err", 32'(frame_err), 32'h0);
    clk_n(10);
    check("t1_dac_a_buffered", 32'(dac_a), 32'h0);
    ldac_pulse();
    check("t1_valid_once", 32'(vld_cnt - vld_base), 32'd1);
    check("t1_dac_a", 32'(dac_a), 32'hABC);
    check("t1_ctl_a", 32'(ctl_a), 32'h4);
    check_rd("t1_rd0", BASE, 8'hBC);
    check_rd("t1_rd1", BASE + 8'd1, 8'h4A);
    check_rd("t1_rd4", BASE + 8'd4, 8'h01);

    // Frame 9123 with nLDAC high: input reg only
    send_frame(16'h9123);
    check("t2_dac_b_held", 32'(dac_b), 32'h0);
    check("t2_dac_a_kept", 32'(dac_a), 32'hABC);
    check_rd("t2_status", BASE + 8'd5, 8'h00);
    ldac_pulse();
    check("t2_dac_b", 32'(dac_b), 32'h123);
    check("t2_ctl_b", 32'(ctl_b), 32'h4);
    check_rd("t2_rd2", BASE + 8'd2, 8'h23);
    check_rd("t2_rd3", BASE + 8'd3, 8'h41);
    check_rd("t2_rd_above", BASE + 8'd6, 8'h00);
    check_rd("t2_rd_below", BASE - 8'd1, 8'h00);

    // Held-low nLDAC does not retransfer a newly committed code
    nLDAC = 1'b0;
    clk_n(6);
    send_frame(16'h0777);
    check("hold_dac_a", 32'(dac_a), 32'hABC);
    nLDAC = 1'b1;
    clk_n(6);
    ldac_pulse();
    check("hold_dac_a_after", 32'(dac_a), 32'h777);
    check("hold_ctl_a_after", 32'(ctl_a), 32'h0);

    // 15-bit, 17-bit and zero-edge frames are rejected
    err_base = err_cnt;
    vld_base = vld_cnt;
    send_bits(32'h7FFF, 15);
    end_frame();
    send_bits(32'h1_5555, 17);
    end_frame();
    nCS = 1'b0;
    clk_n(6);
    check_rd("t3_busy", BASE + 8'd5, 8'h03);
    end_frame();
    check("t3_err_pulses", 32'(err_cnt - err_base), 32'd3);
    check("t3_no_valid", 32'(vld_cnt - vld_base), 32'd0);
    check_rd("t3_cnt", BASE + 8'd4, 8'h03);
    check_rd("t3_status", BASE + 8'd5, 8'h02);
    check("t3_dac_a", 32'(dac_a), 32'h777);
    check("t3_dac_b", 32'(dac_b), 32'h123);

    // nLDAC fall lands on the CHECK commit cycle of frame 1555
    send_bits(32'h1555, 16);
    nCS = 1'b1;
    clk_n(1);
    nLDAC = 1'b0;
    clk_n(3);
    check("t4_commit_cycle", 32'(frame_valid), 32'h1);
    clk_n(4);
    check("t4_dac_a_old", 32'(dac_a), 32'h777);
    nLDAC = 1'b1;
    clk_n(6);
    ldac_pulse();
    check("t4_dac_a_new", 32'(dac_a), 32'h555);
    check("t4_ctl_a_new", 32'(ctl_a), 32'h4);

    // frame_cnt is 4 here; 251 frames reach 255, one more wraps to 0
    for (int i = 0; i < 251; i++) send_frame(16'h1000 | 16'(i));
    check_rd("t5_cnt_255", BASE + 8'd4, 8'hFF);
    send_frame(16'h9FFF);
    check_rd("t5_cnt_wrap", BASE + 8'd4, 8'h00);

    // Reset after 8 bits of a frame
    vld_base = vld_cnt;
    err_base = err_cnt;
    send_bits(32'hA5, 8);
    reset = 1'b1;
    clk_n(3);
    nCS = 1'b1;
    clk_n(2);
    reset = 1'b0;
    clk_n(12);
    check("rst5_no_valid", 32'(vld_cnt - vld_base), 32'd0);
    check("rst5_no_err", 32'(err_cnt - err_base), 32'd0);
    check("rst5_dac_a", 32'(dac_a), 32'h0);
    check("rst5_dac_b", 32'(dac_b), 32'h0);
    check("rst5_ctl", 32'({ctl_a, ctl_b}), 32'h0);
    check_rd("rst5_cnt", BASE + 8'd4, 8'h00);
    check_rd("rst5_status", BASE + 8'd5, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
